// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu_core slice.
// - state_t  : FSM state encoding (FETCH, DECODE, EXECUTE, HALT)
// - opcode_t : instruction opcodes; values C..E have no entry and execute as NOP
// - Instruction field positions, datapath and address widths
package cpu_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned PC_W      = 16;
  localparam int unsigned NUM_REGS  = 16;
  localparam int unsigned REG_IDX_W = 4;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 28;
  localparam int unsigned RD_MSB  = 27;
  localparam int unsigned RD_LSB  = 24;
  localparam int unsigned RS1_MSB = 23;
  localparam int unsigned RS1_LSB = 20;
  localparam int unsigned RS2_MSB = 19;
  localparam int unsigned RS2_LSB = 16;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    HALT    = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SLL  = 4'h6,
    OP_SRL  = 4'h7,
    OP_ADDI = 4'h8,
    OP_SLT  = 4'h9,
    OP_JMP  = 4'hA,
    OP_BEQ  = 4'hB,
    OP_HALT = 4'hF
  } opcode_t;

  // Opcodes that produce a value for rd.
  function automatic logic writes_rd(opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_ADDI, OP_SLT: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/single_port_ram_port_if.sv
// Bus between the CPU and a single-port synchronous-read RAM.
// - addr  : read/write address (CPU -> RAM)
// - wdata : write data (CPU -> RAM)
// - we    : write enable (CPU -> RAM)
// - rdata : read data, valid one cycle after addr (RAM -> CPU)
interface single_port_ram_port_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  we;
  logic [DATA_WIDTH-1:0] rdata;

  modport CPU (output addr, output wdata, output we, input rdata);
  modport RAM (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/register_bank.sv
// 16 x 32 register file.
// - clock, reset          : system clock, synchronous active-high reset (clears all entries)
// - rd_addr_a / rd_data_a : asynchronous read port A
// - rd_addr_b / rd_data_b : asynchronous read port B
// - wr_en, wr_addr, wr_data : synchronous write port; writes to R0 are dropped
// R0 reads as zero regardless of the array contents.
module register_bank
  import cpu_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0]    rd_data_a,
  input  logic [REG_IDX_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]    rd_data_b,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_data
);

  logic [DATA_W-1:0] regs [0:NUM_REGS-1];

  // Reset takes priority so an instruction cut short by reset never commits.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i[REG_IDX_W-1:0]] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle 32-bit register CPU: FETCH -> DECODE -> EXECUTE per instruction,
// instructions read from a word-addressed synchronous RAM (never written).
// - clock    : system clock, rising edge
// - reset    : synchronous, active-high
// - mem_port : CPU side of the RAM bus; addr = PC[7:0], wdata/we tied to 0
module cpu_core
  import cpu_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  single_port_ram_port_if.CPU     mem_port
);

  state_t                 current_state;
  logic [PC_W-1:0]        pc;
  logic [DATA_W-1:0]      instrucao_atual;

  opcode_t                op;
  logic [REG_IDX_W-1:0]   rd, rs1, rs2;
  logic [15:0]            imm16;
  logic [DATA_W-1:0]      opa, opb, result;
  logic [PC_W-1:0]        next_pc;
  logic                   wr_en;

  assign op    = opcode_t'(instrucao_atual[OPC_MSB:OPC_LSB]);
  assign rd    = instrucao_atual[RD_MSB:RD_LSB];
  assign rs1   = instrucao_atual[RS1_MSB:RS1_LSB];
  assign rs2   = instrucao_atual[RS2_MSB:RS2_LSB];
  assign imm16 = instrucao_atual[IMM_MSB:IMM_LSB];

  // BEQ compares rd against rs1, so port B is steered to rd for that opcode.
  register_bank rb_inst (
    .clock     (clock),
    .reset     (reset),
    .rd_addr_a (rs1),
    .rd_data_a (opa),
    .rd_addr_b ((op == OP_BEQ) ? rd : rs2),
    .rd_data_b (opb),
    .wr_en     (wr_en),
    .wr_addr   (rd),
    .wr_data   (result)
  );

  assign wr_en = (current_state == EXECUTE) && writes_rd(op);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = opa + opb;
      OP_SUB:  result = opa - opb;
      OP_AND:  result = opa & opb;
      OP_OR:   result = opa | opb;
      OP_XOR:  result = opa ^ opb;
      OP_SLL:  result = opa << opb[4:0];
      OP_SRL:  result = opa >> opb[4:0];
      OP_ADDI: result = opa + {{16{imm16[15]}}, imm16};
      OP_SLT:  result = {31'b0, ($signed(opa) < $signed(opb))};
      default: result = '0;
    endcase
  end

  always_comb begin
    next_pc = pc + 16'd1;
    case (op)
      OP_JMP:  next_pc = imm16;
      OP_BEQ:  if (opb == opa) next_pc = imm16;
      OP_HALT: next_pc = pc;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      current_state   <= FETCH;
      pc              <= '0;
      instrucao_atual <= '0;
    end else begin
      case (current_state)
        FETCH:   current_state <= DECODE;
        DECODE: begin
          instrucao_atual <= mem_port.rdata;
          current_state   <= EXECUTE;
        end
        EXECUTE: begin
          pc            <= next_pc;
          current_state <= (op == OP_HALT) ? HALT : FETCH;
        end
        default: current_state <= HALT;
      endcase
    end
  end

  assign mem_port.addr  = pc[ADDR_W-1:0];
  assign mem_port.wdata = '0;
  assign mem_port.we    = 1'b0;

endmodule

// File: tb/tb_cpu_core.sv
module tb_cpu_core;
  import cpu_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  single_port_ram_port_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) mem_if ();

  cpu_core dut (
    .clock    (clock),
    .reset    (reset),
    .mem_port (mem_if.CPU)
  );

  // Synchronous-read instruction memory.
  logic [31:0] mem [0:255];
  always @(posedge clock) mem_if.rdata <= mem[mem_if.addr];

  int total = 0;
  int bad   = 0;

  // Reference machine state, advanced one whole instruction at a time.
  logic [15:0] m_pc;
  logic [31:0] m_regs [16];
  logic        m_halted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, rd, rs1, rs2, input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000;
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    m_halted = 1'b0;
  endtask

  task automatic model_exec();
    logic [31:0] w, a, b, c, res;
    logic [3:0]  op, rd;
    logic [15:0] imm;
    logic        wr;
    w   = mem[m_pc[7:0]];
    op  = w[31:28];
    rd  = w[27:24];
    a   = m_regs[w[23:20]];
    b   = m_regs[w[19:16]];
    c   = m_regs[rd];
    imm = w[15:0];
    wr  = 1'b1;
    res = 32'h0;
    case (op)
      4'h1: res = a + b;
      4'h2: res = a - b;
      4'h3: res = a & b;
      4'h4: res = a | b;
      4'h5: res = a ^ b;
      4'h6: res = a << b[4:0];
      4'h7: res = a >> b[4:0];
      4'h8: res = a + 32'($signed(imm));
      4'h9: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: wr = 1'b0;
    endcase
    if (wr && rd != 4'd0) m_regs[rd] = res;
    case (op)
      4'hA: m_pc = imm;
      4'hB: m_pc = (c == a) ? imm : m_pc + 16'd1;
      4'hF: m_halted = 1'b1;
      default: m_pc = m_pc + 16'd1;
    endcase
  endtask

  task automatic check_arch(input string ctx);
    check({ctx, ".pc"}, 32'(dut.pc), 32'(m_pc));
    check({ctx, ".addr"}, 32'(mem_if.addr), 32'(m_pc[7:0]));
    for (int i = 0; i < 16; i++)
      check($sformatf("%s.r%0d", ctx, i), dut.rb_inst.regs[i], m_regs[i]);
  endtask

  // Holds reset for n edges, checks the reset state, then releases it.
  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clock);
    #1;
    model_reset();
    check("rst.state", 32'(dut.current_state), 32'(FETCH));
    check("rst.instr", dut.instrucao_atual, 32'h0);
    check("rst.we", 32'(mem_if.we), 32'h0);
    check("rst.wdata", mem_if.wdata, 32'h0);
    check_arch("rst");
    reset = 1'b0;
  endtask

  task automatic run_instr();
    @(posedge clock); #1;
    check("trace.decode", 32'(dut.current_state), 32'(DECODE));
    check("trace.addr", 32'(mem_if.addr), 32'(m_pc[7:0]));
    @(posedge clock); #1;
    check("trace.execute", 32'(dut.current_state), 32'(EXECUTE));
    check("trace.instr", dut.instrucao_atual, mem[m_pc[7:0]]);
    @(posedge clock); #1;
    model_exec();
    check("trace.next", 32'(dut.current_state), m_halted ? 32'(HALT) : 32'(FETCH));
    check_arch("exec");
  endtask

  logic [3:0]  rand_ops [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                 4'h7, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE};
  int          r;
  logic [3:0]  rrd;
  logic [31:0] snap [16];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    // Directed program.
    mem[8'h00] = enc(4'h8, 4'd1, 4'd0, 4'd0, 16'h0003);  // ADDI R1,R0,3
    mem[8'h01] = enc(4'h8, 4'd2, 4'd0, 4'd0, 16'h0007);  // ADDI R2,R0,7
    mem[8'h02] = enc(4'h1, 4'd3, 4'd1, 4'd2, 16'h0);
    mem[8'h03] = enc(4'h2, 4'd4, 4'd2, 4'd1, 16'h0);
    mem[8'h04] = enc(4'h2, 4'd5, 4'd1, 4'd2, 16'h0);
    mem[8'h05] = enc(4'h3, 4'd6, 4'd1, 4'd2, 16'h0);
    mem[8'h06] = enc(4'h4, 4'd7, 4'd1, 4'd2, 16'h0);
    mem[8'h07] = enc(4'h5, 4'd8, 4'd1, 4'd2, 16'h0);
    mem[8'h08] = enc(4'h6, 4'd9, 4'd1, 4'd2, 16'h0);
    mem[8'h09] = enc(4'h8, 4'd9, 4'd0, 4'd0, 16'hFFFF);
    mem[8'h0A] = enc(4'h1, 4'd0, 4'd1, 4'd2, 16'h0);
    mem[8'h0B] = enc(4'hA, 4'd0, 4'd0, 4'd0, 16'h0010);
    mem[8'h10] = enc(4'hB, 4'd1, 4'd1, 4'd0, 16'h0020);  // BEQ R1,R1 taken
    mem[8'h20] = enc(4'hB, 4'd1, 4'd2, 4'd0, 16'h0020);  // BEQ R1,R2 not taken
    mem[8'h21] = enc(4'hA, 4'd0, 4'd0, 4'd0, 16'h0040);
    // Random program region, no HALT.
    for (int a = 64; a < 256; a++) begin
      r = $urandom_range(0, 99);
      if (r < 10)
        mem[a[7:0]] = enc(4'hA, 4'($urandom), 4'($urandom), 4'($urandom),
                          {8'($urandom_range(0, 255)), 8'($urandom_range(64, 255))});
      else if (r < 20) begin
        rrd = 4'($urandom);
        mem[a[7:0]] = enc(4'hB, rrd, (r < 15) ? rrd : 4'($urandom), 4'($urandom),
                          {8'($urandom_range(0, 255)), 8'($urandom_range(64, 255))});
      end else
        mem[a[7:0]] = enc(rand_ops[$urandom_range(0, 12)], 4'($urandom), 4'($urandom),
                          4'($urandom), 16'($urandom));
    end

    do_reset(5);
    repeat (9) run_instr();
    check("add", dut.rb_inst.regs[3], 32'h0000000A);
    check("sub_pos", dut.rb_inst.regs[4], 32'h00000004);
    check("sub_neg", dut.rb_inst.regs[5], 32'hFFFFFFFC);
    check("and", dut.rb_inst.regs[6], 32'h00000003);
    check("or", dut.rb_inst.regs[7], 32'h00000007);
    check("xor", dut.rb_inst.regs[8], 32'h00000004);
    check("sll", dut.rb_inst.regs[9], 32'h00000180);
    repeat (2) run_instr();
    check("addi_sext", dut.rb_inst.regs[9], 32'hFFFFFFFF);
    check("r0_write", dut.rb_inst.regs[0], 32'h0);
    run_instr();
    check("jmp_pc", 32'(dut.pc), 32'h0010);
    run_instr();
    check("beq_taken", 32'(dut.pc), 32'h0020);
    run_instr();
    check("beq_not_taken", 32'(dut.pc), 32'h0021);
    run_instr();
    repeat (80) run_instr();

    // PC wrap: 0xFFFF + 1 -> 0x0000, addr follows PC[7:0].
    reset = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h00] = enc(4'hA, 4'd0, 4'd0, 4'd0, 16'hFFFF);
    mem[8'hFF] = enc(4'h8, 4'd10, 4'd10, 4'd0, 16'h0005);
    do_reset(3);
    repeat (4) run_instr();
    check("pc_wrap", 32'(dut.pc), 32'h0000);

    // Reset during DECODE of ADD R3, then during EXECUTE of it.
    reset = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h00] = enc(4'h8, 4'd1, 4'd0, 4'd0, 16'h0003);
    mem[8'h01] = enc(4'h8, 4'd2, 4'd0, 4'd0, 16'h0007);
    mem[8'h02] = enc(4'h1, 4'd3, 4'd1, 4'd2, 16'h0);
    mem[8'h03] = enc(4'h8, 4'd4, 4'd4, 4'd0, 16'h8000);
    mem[8'h04] = enc(4'h5, 4'd8, 4'd4, 4'd1, 16'h0);
    mem[8'h05] = enc(4'hF, 4'd0, 4'd0, 4'd0, 16'h0);
    do_reset(2);
    repeat (2) run_instr();
    @(posedge clock); #1;
    check("pre_abort.state", 32'(dut.current_state), 32'(DECODE));
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_dec.state", 32'(dut.current_state), 32'(FETCH));
    check("abort_dec.pc", 32'(dut.pc), 32'h0);
    check("abort_dec.r3", dut.rb_inst.regs[3], 32'h0);
    do_reset(1);
    repeat (2) run_instr();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_exe.r3", dut.rb_inst.regs[3], 32'h0);
    check("abort_exe.pc", 32'(dut.pc), 32'h0);

    // HALT at address 5.
    do_reset(2);
    repeat (6) run_instr();
    check("halt.state", 32'(dut.current_state), 32'(HALT));
    check("halt.pc", 32'(dut.pc), 32'h0005);
    for (int i = 0; i < 16; i++) snap[i] = m_regs[i];
    repeat (40) @(posedge clock);
    #1;
    check("halt_hold.state", 32'(dut.current_state), 32'(HALT));
    check_arch("halt_hold");
    for (int i = 0; i < 16; i++)
      check($sformatf("halt_snap.r%0d", i), dut.rb_inst.regs[i], snap[i]);
    do_reset(1);
    check("post_halt.pc", 32'(dut.pc), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
# cpu_core

Multi-cycle 32-bit accumulator-free register CPU that fetches one 32-bit instruction per pass from a word-addressed single-port RAM and executes ALU, immediate and branch operations on a 16×32 register bank. It sits between the system clock/reset and the `single_port_ram` instance, to which it connects through the `single_port_ram_port_if` CPU modport. The memory is used for instruction fetch only and is never written.

## Interface
- Parameters: none. Fixed values: data width 32, memory address width 8, PC width 16, 16 registers.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clock` input 1: system clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `mem_port` modport CPU of `single_port_ram_port_if` (ADDR_WIDTH=8, DATA_WIDTH=32):
  - `addr` output 8: read address.
  - `wdata` output 32: write data, tied to 0.
  - `we` output 1: write enable, tied to 0.
  - `rdata` input 32: read data from the RAM.
- The RAM reads synchronously: `rdata` is valid one cycle after `addr` is presented.

## Operation
- Instruction fields:
  - opcode [31:28]
  - rd [27:24]
  - rs1 [23:20]
  - rs2 [19:16]
  - imm16 [15:0], sign-extended for ADDI.
- Opcodes:
  - 0 NOP.
  - 1 ADD: rd=rs1+rs2.
  - 2 SUB: rd=rs1−rs2.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SLL: rd=rs1<<rs2[4:0].
  - 7 SRL, logical.
  - 8 ADDI: rd=rs1+sext(imm16).
  - 9 SLT: rd = (signed rs1 < signed rs2) ? 1 : 0.
  - A JMP: PC=imm16.
  - B BEQ: if rd==rs1 then PC=imm16, else PC+1.
  - F HALT.
  - C–E behave as NOP.
- Arithmetic is 32-bit two's complement, wrap-around, with no flags.
- R0 always reads 0. Writes to R0 are discarded.
- The register array is a plain variable array `regs[0:15]` inside the register bank instance `rb_inst`, so a bench can force or release individual entries.
- PC is 16 bits and wraps at 0xFFFF. `addr` = PC[7:0], so the program space wraps every 256 words.
- Internal signal `instrucao_atual` (32-bit) holds the latched instruction.
- `current_state` is a 2-bit enum:
  - FETCH=0: present PC on `addr`; go to DECODE.
  - DECODE=1: latch `rdata` into `instrucao_atual`; go to EXECUTE.
  - EXECUTE=2: read operands, write rd, update PC (+1, jump target, or unchanged for HALT); go to FETCH, or to HALT for opcode F.
  - HALT=3: stay in HALT. PC, registers and `addr` are frozen until reset.

## Timing
- Reset values: PC=0, state=FETCH, `instrucao_atual`=0, all regs=0, `addr`=0, `we`=0, `wdata`=0.
- Reset asserted mid-instruction aborts it on the next edge. No register write from the aborted instruction is committed.
- Each instruction takes 3 cycles (FETCH, DECODE, EXECUTE).
- The register write and the PC update both occur on the EXECUTE→FETCH edge.
- The next instruction's FETCH sees the updated registers, so there is no hazard.
- `addr` is driven combinationally from PC in every state.
- Reading and writing the same register in one instruction (e.g. rd=rs1): operands are read before the write.

## Structure
- Package `cpu_pkg` holds:
  - `state_t` (FETCH, DECODE, EXECUTE, HALT as logic[1:0]), so `.name()` works.
  - `opcode_t` enum.
  - Field bit positions and width constants.
- Sub-module `register_bank`, instantiated as `rb_inst`: 2 asynchronous read ports, 1 synchronous write port, R0 write guard, `regs` array.
- The ALU and the FSM stay in `cpu_core`.

## Test plan
- Reset held 5 cycles, then released:
  - PC=0000, state FETCH, all regs 0.
  - Trace shows FETCH→DECODE→EXECUTE with PC incrementing every 3 cycles.
- Force R1=3, R2=7, then run ADD R3,R1,R2; SUB R4,R2,R1; SUB R5,R1,R2; AND R6; OR R7; XOR R8 (each R1 op R2). Required:
  - R3=0000000A
  - R4=00000004
  - R5=FFFFFFFC
  - R6=00000003
  - R7=00000007
  - R8=00000004
- SLL R9,R1,R2 → 00000180. ADDI R9,R0,0xFFFF → FFFFFFFF. ADD R0,R1,R2 → R0 stays 0.
- JMP 0x0010 → next PC=0010. BEQ R1,R1,0x0020 → PC=0020. BEQ R1,R2,0x0020 → PC+1.
- HALT at address 5:
  - State HALT, PC=0005.
  - Registers unchanged over 40 further cycles.
  - Asserting reset returns to FETCH with PC=0000.
- Reset asserted during DECODE of ADD R3 → R3 remains 0 and PC=0000.
